// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, requester IDs and the
// read tag carried through the response pipeline.
package memory_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/memory_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that was not granted last wins.
module rr_arb2
  import memory_arbiter_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && (!valid1 || last_grant == REQ1_ID)) begin
      grant[0] = 1'b1;
    end else if (valid1) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM controller: fills mem[a]=a after reset, then shares the RAM between two
// requesters with round-robin arbitration and returns read data after RD_LAT cycles.
//
// Handshake: a request is accepted on a rising edge where reqN_valid && reqN_ready.
// reqN_ready is combinational from both valids, so valid must never wait for ready.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int INIT_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done,
  output logic              dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_grant;
  logic [1:0]        grant;
  logic              run;
  logic              filling;
  logic              rd_acc;
  logic              gnt_id;
  tag_t              tag_pipe [RD_LAT];

  assign run       = (state == ST_RUN);
  assign dbg_state = state;
  // Qualified by reset so the RAM sees no write strobe while reset is held.
  assign filling   = (state == ST_INIT) && reset;

  rr_arb2 u_arb (
    .valid0     (req0_valid && run),
    .valid1     (req1_valid && run),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign gnt_id     = grant[1] ? REQ1_ID : REQ0_ID;
  assign rd_acc     = (grant[0] && !req0_we) || (grant[1] && !req1_we);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (filling) begin
      mem_we    = 1'b1;
      mem_addr  = fill_cnt;
      mem_wdata = DATA_W'(fill_cnt);
    end else if (grant[0]) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (grant[1]) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      fill_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= REQ1_ID;
      init_done  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          addr_q   <= fill_cnt;
          wdata_q  <= DATA_W'(fill_cnt);
          if (fill_cnt == '1) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          init_done <= 1'b1;
          if (|grant) begin
            last_grant <= gnt_id;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
          end
        end
      endcase

      // The tag leaving the last stage lines up with the RAM output for that read.
      tag_pipe[0] <= '{valid: rd_acc, id: gnt_id};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (tag_pipe[RD_LAT-1].valid) begin
        if (tag_pipe[RD_LAT-1].id == REQ0_ID) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= mem_rdata;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: RAM models, a response scoreboard, and one task per scenario.
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0] req0_addr = '0, req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req1_addr = '0, req1_wdata = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, init_done, dbg_state;

  // Second instance: RD_LAT=2, 16-entry RAM, used for the latency scenario.
  logic       b_reset = 1'b0;
  logic       b_req0_valid = 1'b0, b_req0_we = 1'b0;
  logic [3:0] b_req0_addr = '0;
  logic [7:0] b_req0_wdata = '0;
  logic       b_req1_valid = 1'b0, b_req1_we = 1'b0;
  logic [3:0] b_req1_addr = '0;
  logic [7:0] b_req1_wdata = '0;
  logic       b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [7:0] b_rsp0_rdata, b_rsp1_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0] b_mem_addr;
  logic       b_mem_we, b_init_done, b_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic       exp_last = 1'b1;

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done), .dbg_state(dbg_state)
  );

  memory_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .INIT_EN(1)) dut2 (
    .clk(clk), .reset(b_reset),
    .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr),
    .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr),
    .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
    .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .init_done(b_init_done), .dbg_state(b_dbg_state)
  );

  // Single-port RAMs: address captured at the edge, data valid RD_LAT edges later.
  logic [7:0] ram [256];
  logic [7:0] ram_rd;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_rd <= ram[mem_addr];
  end
  assign mem_rdata = ram_rd;

  logic [7:0] ram2 [16];
  logic [7:0] ram2_a, ram2_b;
  always @(posedge clk) begin
    if (b_mem_we) ram2[b_mem_addr] <= b_mem_wdata;
    ram2_a <= ram2[b_mem_addr];
    ram2_b <= ram2_a;
  end
  assign b_mem_rdata = ram2_b;

  // Scoreboard consumer: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    logic [8:0] got, exp;
    if (reset && (rsp0_valid || rsp1_valid)) begin
      checks++;
      got = rsp1_valid ? {1'b1, rsp1_rdata} : {1'b0, rsp0_rdata};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got id=%0d data=%h, none expected", got[8], got[7:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL rsp_data got id=%0d data=%h, expected id=%0d data=%h",
                   got[8], got[7:0], exp[8], exp[7:0]);
        end
      end
    end
  end

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (init_done) break;
    end
  endtask

  task automatic do_req(input logic id, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_data);
    logic ok = 1'b0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        checks++;
        if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) begin
          errors++;
          $display("FAIL mem_drive got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, we, addr, wdata);
        end
        if (!we) exp_q.push_back({id, exp_data});
        exp_last = id;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got ready=0, expected accept of req%0d addr=%h", id, addr);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we, init_done} !== 6'b0 ||
        mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b%b rsp=%b%b we=%b done=%b addr=%h wd=%h, expected all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we, init_done, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fill;
    int n;
    @(negedge clk);
    reset = 1'b1;
    wait_init(n);
    checks++;
    if (n != 256 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL fill_cycles got %0d (done=%b), expected 256", n, init_done);
    end
    do_req(1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A);
    drain();
  endtask

  task automatic test_round_robin;
    logic g0, g1;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      g0 = (exp_last == 1'b1);
      g1 = !g0;
      checks++;
      if (req0_ready !== g0 || req1_ready !== g1) begin
        errors++;
        $display("FAIL rr_grant cycle %0d got ready=%b%b, expected %b%b",
                 i, req1_ready, req0_ready, g1, g0);
      end
      exp_q.push_back(g0 ? {1'b0, 8'h10} : {1'b1, 8'h20});
      exp_last = g1;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_write_read;
    do_req(1'b0, 1'b1, 8'h80, 8'h33, 8'h00);
    do_req(1'b1, 1'b0, 8'h80, 8'h00, 8'h33);
    do_req(1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF);
    drain();
  endtask

  task automatic test_latency;
    logic ok = 1'b0;
    @(negedge clk);
    b_reset = 1'b1;
    for (int i = 0; i < 40 && !b_init_done; i++) @(negedge clk);
    @(negedge clk);
    b_req0_valid = 1'b1; b_req0_we = 1'b0; b_req0_addr = 4'h5;
    #1;
    checks++;
    if (b_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_ready got %b, expected 1 (init_done=%b)", b_req0_ready, b_init_done);
    end
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    checks++;
    if (b_rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_k got rsp_valid=%b after edge k, expected 0", b_rsp0_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_k1 got rsp_valid=%b after edge k+1, expected 0", b_rsp0_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rsp0_valid !== 1'b1 || b_rsp0_rdata !== 8'h05) begin
      errors++;
      $display("FAIL lat_k2 got rsp_valid=%b data=%h after edge k+2, expected 1 data=05",
               b_rsp0_valid, b_rsp0_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_k3 got rsp_valid=%b after edge k+3, expected 0", b_rsp0_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    int n;
    // Reset from RUN, then again in the middle of the refill.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got init_done=%b, expected 0", init_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_last = 1'b1;
    #1;
    checks++;
    if (init_done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL midfill_reset got done=%b we=%b addr=%h, expected 0 0 00",
               init_done, mem_we, mem_addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL refill_start got we=%b addr=%h wd=%h, expected 1 00 00",
               mem_we, mem_addr, mem_wdata);
    end
    wait_init(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL refill_cycles got %0d, expected 256", n);
    end

    // A read accepted just before reset must never produce a response.
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h11;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL inflight_ready got %b, expected 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL inflight_drop got rsp=%b%b, expected 00", rsp1_valid, rsp0_valid);
      end
    end
  endtask

  task automatic test_hold_init;
    int bad = 0;
    logic seen = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_last = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (init_done) begin
        seen = 1'b1;
        break;
      end
      checks++;
      if (req1_ready !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL init_hold got req1_ready=%b in fill, expected 0", req1_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_run got done=%b req1_ready=%b, expected 1 1", seen, req1_ready);
    end
    if (seen && req1_ready === 1'b1) begin
      exp_q.push_back({1'b1, 8'h77});
      exp_last = 1'b1;
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round_robin();
    test_write_read();
    test_latency();
    test_reset_mid_op();
    test_hold_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
